// File: rtl/yuv_csc_pkg.sv
// Shared types, coefficients and helpers for the YUV->RGB streaming converter.
package yuv_csc_pkg;

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_t;

  localparam int FIR_C0 = 21;
  localparam int FIR_C1 = 52;
  localparam int FIR_C2 = 159;

  localparam int CSC_Y  = 76284;
  localparam int CSC_RV = 104595;
  localparam int CSC_GU = 25624;
  localparam int CSC_GV = 53281;
  localparam int CSC_BU = 132251;

  function automatic logic [7:0] clip8(input int x);
    if (x < 0) return 8'd0;
    else if (x > 255) return 8'd255;
    else return x[7:0];
  endfunction

  // Taps a..f hold U[k-2]..U[k+3]; the sum always fits a signed 20-bit accumulator.
  function automatic logic [7:0] fir6(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d,
                                      input logic [7:0] e, input logic [7:0] f);
    int               s;
    logic signed [19:0] s20;
    s = FIR_C0 * (int'(a) + int'(f)) - FIR_C1 * (int'(b) + int'(e))
      + FIR_C2 * (int'(c) + int'(d)) + 128;
    s20 = 20'(s);
    return clip8(int'(s20 >>> 8));
  endfunction

endpackage

// File: rtl/yuv2rgb_pixel.sv
// Combinational colour-space conversion and clipping for a single pixel.
module yuv2rgb_pixel
  import yuv_csc_pkg::*;
(
  input  logic [7:0]  i_y,
  input  logic [7:0]  i_u,
  input  logic [7:0]  i_v,
  output logic [23:0] o_rgb
);

  logic signed [31:0] w_yt, w_ut, w_vt;
  logic signed [31:0] w_r, w_g, w_b;

  assign w_yt = CSC_Y * ($signed({24'd0, i_y}) - 32'sd16);
  assign w_ut = $signed({24'd0, i_u}) - 32'sd128;
  assign w_vt = $signed({24'd0, i_v}) - 32'sd128;

  assign w_r = (w_yt + CSC_RV * w_vt) >>> 16;
  assign w_g = (w_yt - CSC_GU * w_ut - CSC_GV * w_vt) >>> 16;
  assign w_b = (w_yt + CSC_BU * w_ut) >>> 16;

  assign o_rgb = {clip8(w_r), clip8(w_g), clip8(w_b)};

endmodule

// File: rtl/yuv_csc_stream.sv
// Streaming YUV pair -> RGB pair converter with 6-tap chroma interpolation,
// per-row edge clamping and a global-stall two-stage output pipeline.
module yuv_csc_stream
  import yuv_csc_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_mode,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [47:0] i_in_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [47:0] o_out_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int P  = WIDTH / 2;
  localparam int PW = $clog2(P + 1);
  localparam int RW = $clog2(HEIGHT + 1);

  state_t          r_state;
  logic            r_mode;
  logic [PW-1:0]   r_pair;
  logic [RW-1:0]   r_row;
  logic [1:0]      r_flush;
  logic [7:0]      r_wu [6];
  logic [7:0]      r_wv [6];
  logic [31:0]     r_yl [4];
  logic            r_s0_valid;
  logic            r_s1_valid;
  logic [7:0]      r_s1_y0, r_s1_y1, r_s1_ue, r_s1_ve, r_s1_uo, r_s1_vo;

  logic            w_stall, w_accept, w_flush_step, w_shift, w_load, w_complete;
  logic [7:0]      w_u_in, w_v_in, w_fir_u, w_fir_v;
  logic [23:0]     w_rgb_e, w_rgb_o;

  assign w_stall      = o_out_valid & ~i_out_ready;
  assign o_in_ready   = ((r_state == FILL) || (r_state == RUN)) && !w_stall;
  assign w_accept     = o_in_ready & i_in_valid;
  assign w_flush_step = (r_state == FLUSH) && !w_stall;
  assign w_shift      = w_accept | w_flush_step;
  assign w_load       = w_accept && (r_state == FILL) && (r_pair == '0);
  assign w_complete   = (w_accept && (r_state == RUN)) || w_flush_step;

  // Flush steps replicate the last chroma sample to clamp the right edge.
  assign w_u_in = w_flush_step ? r_wu[5] : i_in_data[31:24];
  assign w_v_in = w_flush_step ? r_wv[5] : i_in_data[23:16];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 6; i++) begin
        r_wu[i] <= '0;
        r_wv[i] <= '0;
      end
      for (int i = 0; i < 4; i++) r_yl[i] <= '0;
    end else if (w_shift) begin
      for (int i = 0; i < 5; i++) begin
        r_wu[i] <= w_load ? w_u_in : r_wu[i+1];
        r_wv[i] <= w_load ? w_v_in : r_wv[i+1];
      end
      r_wu[5] <= w_u_in;
      r_wv[5] <= w_v_in;
      for (int i = 0; i < 3; i++) r_yl[i] <= r_yl[i+1];
      r_yl[3] <= w_flush_step ? r_yl[3] : {i_in_data[47:32], i_in_data[15:0]};
    end
  end

  assign w_fir_u = fir6(r_wu[0], r_wu[1], r_wu[2], r_wu[3], r_wu[4], r_wu[5]);
  assign w_fir_v = fir6(r_wv[0], r_wv[1], r_wv[2], r_wv[3], r_wv[4], r_wv[5]);

  yuv2rgb_pixel u_even (.i_y(r_s1_y0), .i_u(r_s1_ue), .i_v(r_s1_ve), .o_rgb(w_rgb_e));
  yuv2rgb_pixel u_odd  (.i_y(r_s1_y1), .i_u(r_s1_uo), .i_v(r_s1_vo), .o_rgb(w_rgb_o));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0_valid  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_y0     <= '0;
      r_s1_y1     <= '0;
      r_s1_ue     <= '0;
      r_s1_ve     <= '0;
      r_s1_uo     <= '0;
      r_s1_vo     <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else if (!w_stall) begin
      r_s0_valid  <= w_complete;
      r_s1_valid  <= r_s0_valid;
      r_s1_y0     <= r_yl[0][31:24];
      r_s1_y1     <= r_yl[0][23:16];
      r_s1_ue     <= r_wu[2];
      r_s1_ve     <= r_wv[2];
      r_s1_uo     <= r_mode ? r_yl[0][15:8] : w_fir_u;
      r_s1_vo     <= r_mode ? r_yl[0][7:0]  : w_fir_v;
      o_out_valid <= r_s1_valid;
      if (r_s1_valid) o_out_data <= {w_rgb_e, w_rgb_o};
    end
  end

  // Row/frame sequencing: 3 fill accepts, P-3 run accepts, 3 flush steps per row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_pair  <= '0;
      r_row   <= '0;
      r_flush <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: if (i_enable) begin
          r_state <= FILL;
          r_mode  <= i_mode;
          r_pair  <= '0;
          r_row   <= '0;
          o_busy  <= 1'b1;
        end
        FILL: if (w_accept) begin
          r_pair <= r_pair + 1'b1;
          if (r_pair == PW'(2)) r_state <= RUN;
        end
        RUN: if (w_accept) begin
          if (r_pair == PW'(P - 1)) begin
            r_pair  <= '0;
            r_flush <= '0;
            r_state <= FLUSH;
          end else begin
            r_pair <= r_pair + 1'b1;
          end
        end
        FLUSH: if (!w_stall) begin
          if (r_flush == 2'd2) begin
            if (r_row == RW'(HEIGHT - 1)) begin
              r_state <= DRAIN;
            end else begin
              r_row   <= r_row + 1'b1;
              r_state <= FILL;
            end
          end else begin
            r_flush <= r_flush + 1'b1;
          end
        end
        DRAIN: if (o_out_valid && i_out_ready && !r_s1_valid && !r_s0_valid) begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
